// File: rtl/ads1672_pkg.sv
// ads1672_pkg: shared width, FSM state and sample types for the ADS1672 emulator
package ads1672_pkg;
    localparam int ADS1672_DATA_WIDTH = 24;
    typedef enum logic [1:0] {ST_IDLE, ST_CONVERT, ST_READY, ST_SHIFT} ads1672_emu_state_t;
    typedef logic signed [ADS1672_DATA_WIDTH-1:0] ads1672_sample_t;
endpackage

// File: rtl/ads1672_pattern_gen.sv
// ads1672_pattern_gen: free-running ramp that advances by step on each enabled cycle
module ads1672_pattern_gen
    import ads1672_pkg::*;
#(
    parameter int DATA_WIDTH = ADS1672_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] step,
    output logic [DATA_WIDTH-1:0] sample
);
    always_ff @(posedge clk)
        if (rst) sample <= '0;
        else if (en) sample <= sample + step;
endmodule

// File: rtl/ads1672_adc_emulator.sv
// ads1672_adc_emulator: device-side conversion timer, data-ready handshake and MSB-first serial read-out
module ads1672_adc_emulator
    import ads1672_pkg::*;
#(
    parameter int DATA_WIDTH  = ADS1672_DATA_WIDTH,
    parameter int CONV_CYCLES = 64,
    parameter bit USE_RAMP    = 1'b1,
    parameter int RAMP_STEP   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  fsx,
    input  logic [DATA_WIDTH-1:0] sample_in,
    output logic                  drdy_n,
    output logic                  fsr,
    output logic                  drr,
    output logic                  overrun,
    output logic                  busy
);
    localparam int CW = $clog2(CONV_CYCLES);
    localparam int BW = $clog2(DATA_WIDTH);

    if (CONV_CYCLES <= DATA_WIDTH + 2) begin : g_bad_conv
        $error("CONV_CYCLES must exceed DATA_WIDTH+2");
    end

    ads1672_emu_state_t state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [BW-1:0] bcnt, bcnt_nxt;
    logic [DATA_WIDTH-1:0] hold, hold_nxt, sreg, sreg_nxt, ramp;
    logic pending, pend_nxt, drdy_nxt, fsr_nxt, drr_nxt, ovr_nxt, tick;

    assign tick = (state != ST_IDLE) && start && (cnt == CW'(CONV_CYCLES - 1));
    assign busy = (state == ST_SHIFT);

    ads1672_pattern_gen #(.DATA_WIDTH(DATA_WIDTH)) u_pattern_gen (
        .clk    (clk),
        .rst    (rst),
        .en     (tick),
        .step   (DATA_WIDTH'(RAMP_STEP)),
        .sample (ramp)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        bcnt_nxt  = bcnt;
        hold_nxt  = hold;
        sreg_nxt  = sreg;
        pend_nxt  = pending;
        drdy_nxt  = drdy_n;
        fsr_nxt   = 1'b0;
        drr_nxt   = 1'b0;
        ovr_nxt   = 1'b0;
        if (!start) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
            pend_nxt  = 1'b0;
            drdy_nxt  = 1'b1;
        end else begin
            if (state != ST_IDLE) cnt_nxt = tick ? '0 : cnt + CW'(1);
            if (tick) hold_nxt = USE_RAMP ? ramp : sample_in;
            case (state)
                ST_IDLE: state_nxt = ST_CONVERT;
                ST_CONVERT:
                    if (tick) begin
                        state_nxt = ST_READY;
                        drdy_nxt  = 1'b0;
                        fsr_nxt   = 1'b1;
                    end
                ST_READY:
                    // A read wins over a coincident tick: the old word is shifted, the new one waits
                    if (fsx) begin
                        state_nxt = ST_SHIFT;
                        drdy_nxt  = 1'b1;
                        drr_nxt   = hold[DATA_WIDTH-1];
                        sreg_nxt  = hold << 1;
                        bcnt_nxt  = BW'(DATA_WIDTH - 1);
                        pend_nxt  = tick;
                    end else if (tick) begin
                        ovr_nxt  = 1'b1;
                        drdy_nxt = 1'b1;
                    end else if (overrun) begin
                        drdy_nxt = 1'b0;
                        fsr_nxt  = 1'b1;
                    end
                ST_SHIFT:
                    if (bcnt != '0) begin
                        drr_nxt  = sreg[DATA_WIDTH-1];
                        sreg_nxt = sreg << 1;
                        bcnt_nxt = bcnt - BW'(1);
                        pend_nxt = pending | tick;
                    end else begin
                        pend_nxt  = 1'b0;
                        state_nxt = (pending | tick) ? ST_READY : ST_CONVERT;
                        drdy_nxt  = !(pending | tick);
                        fsr_nxt   = pending | tick;
                    end
            endcase
        end
    end

    always_ff @(posedge clk)
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bcnt    <= '0;
            hold    <= '0;
            sreg    <= '0;
            pending <= 1'b0;
            drdy_n  <= 1'b1;
            fsr     <= 1'b0;
            drr     <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bcnt    <= bcnt_nxt;
            hold    <= hold_nxt;
            sreg    <= sreg_nxt;
            pending <= pend_nxt;
            drdy_n  <= drdy_nxt;
            fsr     <= fsr_nxt;
            drr     <= drr_nxt;
            overrun <= ovr_nxt;
        end
endmodule

// File: tb/tb_ads1672_adc_emulator.sv
// tb_ads1672_adc_emulator: directed/randomized checks of three emulator configurations against a timing model
module tb_ads1672_adc_emulator;
    import ads1672_pkg::*;
    localparam int W = ADS1672_DATA_WIDTH;

    logic clk = 1'b0, rst = 1'b1;
    logic [2:0] start = '0, fsx = '0;
    logic [2:0] drdy_n, fsr, drr, ovr, busy;
    ads1672_sample_t sample_b = '0;
    int cyc = 0, n_assert = 0, n_fail = 0;
    int t_start [3];
    int base [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ads1672_adc_emulator #(.CONV_CYCLES(64), .USE_RAMP(1'b1)) u_ramp (
        .clk(clk), .rst(rst), .start(start[0]), .fsx(fsx[0]), .sample_in(sample_b),
        .drdy_n(drdy_n[0]), .fsr(fsr[0]), .drr(drr[0]), .overrun(ovr[0]), .busy(busy[0]));
    ads1672_adc_emulator #(.CONV_CYCLES(64), .USE_RAMP(1'b0)) u_ext (
        .clk(clk), .rst(rst), .start(start[1]), .fsx(fsx[1]), .sample_in(sample_b),
        .drdy_n(drdy_n[1]), .fsr(fsr[1]), .drr(drr[1]), .overrun(ovr[1]), .busy(busy[1]));
    ads1672_adc_emulator #(.CONV_CYCLES(30), .USE_RAMP(1'b1)) u_fast (
        .clk(clk), .rst(rst), .start(start[2]), .fsx(fsx[2]), .sample_in(sample_b),
        .drdy_n(drdy_n[2]), .fsr(fsr[2]), .drr(drr[2]), .overrun(ovr[2]), .busy(busy[2]));

    function automatic logic [4:0] outv(input int id);
        return {drdy_n[id], fsr[id], drr[id], ovr[id], busy[id]};
    endfunction

    function automatic int conv(input int id);
        return id == 2 ? 30 : 64;
    endfunction

    // Latest captured ramp value: one capture per elapsed conversion period since start
    function automatic logic [W-1:0] exp_word(input int id, input int creq);
        return W'(base[id] + (creq - t_start[id]) / conv(id) - 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic go(input int id, input int b);
        start[id]   = 1'b1;
        t_start[id] = cyc + 1;
        base[id]    = b;
    endtask

    task automatic wait_fall(input int id, output int c);
        c = -1;
        for (int i = 0; i < 400; i++) begin
            step(1);
            if (drdy_n[id] === 1'b0) begin
                c = cyc;
                break;
            end
        end
    endtask

    task automatic rd_chk(input int id, input string tag, input logic ext, input logic [4:0] post_exp);
        logic [W-1:0] w, e;
        int nb, no;
        e = ext ? W'(sample_b) : exp_word(id, cyc);
        nb = 0;
        no = 0;
        w = '0;
        fsx[id] = 1'b1;
        step(1);
        fsx[id] = 1'b0;
        for (int i = 0; i < W; i++) begin
            w = {w[W-2:0], drr[id]};
            nb += int'(busy[id]);
            no += int'(ovr[id]);
            step(1);
        end
        nb += int'(busy[id]);
        no += int'(ovr[id]);
        chk({tag, "_word"}, 32'(w), 32'(e));
        chk({tag, "_busy"}, nb, W);
        chk({tag, "_ovr"}, no, 0);
        chk({tag, "_post"}, 32'(outv(id)), 32'(post_exp));
    endtask

    initial begin
        logic [W-1:0] w, e;
        int c, hi, fc, oc, oat, nb;
        step(2);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            for (int id = 0; id < 3; id++) chk("idle", 32'(outv(id)), 32'(5'b10000));
        end

        go(0, 0);
        step(10);
        fsx[0] = 1'b1;
        step(1);
        fsx[0] = 1'b0;
        chk("fsx_ignored_convert", 32'(busy[0]), 0);
        wait_fall(0, c);
        chk("first_fall", c, t_start[0] + 64);
        chk("fsr_on_fall", 32'(fsr[0]), 1);
        step(1);
        chk("fsr_one_cycle", 32'({drdy_n[0], fsr[0]}), 0);
        step($urandom_range(1, 20));
        rd_chk(0, "ramp0", 1'b0, 5'b10000);
        wait_fall(0, c);
        chk("second_fall", c, t_start[0] + 128);
        step($urandom_range(1, 20));
        rd_chk(0, "ramp1", 1'b0, 5'b10000);

        wait_fall(0, c);
        chk("third_fall", c, t_start[0] + 192);
        hi = 0; fc = 0; oc = 0; oat = -1;
        for (int i = 0; i < 70; i++) begin
            step(1);
            hi += int'(drdy_n[0]);
            fc += int'(fsr[0]);
            oc += int'(ovr[0]);
            if (ovr[0]) oat = cyc;
        end
        chk("ovr_count", oc, 1);
        chk("ovr_cycle", oat, t_start[0] + 256);
        chk("ovr_drdy_high", hi, 1);
        chk("ovr_fsr", fc, 1);
        rd_chk(0, "after_ovr", 1'b0, 5'b10000);

        wait_fall(0, c);
        chk("fifth_fall", c, t_start[0] + 320);
        step($urandom_range(1, 10));
        e = exp_word(0, cyc);
        fsx[0] = 1'b1;
        step(1);
        fsx[0] = 1'b0;
        w = '0;
        nb = 0;
        for (int i = 0; i < 10; i++) begin
            w = {w[W-2:0], drr[0]};
            nb += int'(busy[0]);
            if (i < 9) step(1);
        end
        chk("abort_bits", 32'(w[9:0]), 32'(e[W-1 -: 10]));
        chk("abort_busy", nb, 10);
        c = cyc;
        start[0] = 1'b0;
        step(1);
        chk("abort_out", 32'(outv(0)), 32'(5'b10000));
        c = base[0] + (c - t_start[0]) / 64;
        step(3);
        go(0, c);
        wait_fall(0, c);
        chk("restart_fall", c, t_start[0] + 64);
        step($urandom_range(1, 20));
        rd_chk(0, "restart", 1'b0, 5'b10000);
        start[0] = 1'b0;

        sample_b = 24'h800001;
        go(1, 0);
        wait_fall(1, c);
        chk("ext_fall", c, t_start[1] + 64);
        step($urandom_range(1, 20));
        rd_chk(1, "ext_800001", 1'b1, 5'b10000);
        for (int k = 2; k < 5; k++) begin
            sample_b = ads1672_sample_t'($urandom);
            wait_fall(1, c);
            chk("ext_fall_k", c, t_start[1] + 64 * k);
            step($urandom_range(1, 20));
            rd_chk(1, "ext_rand", 1'b1, 5'b10000);
        end
        start[1] = 1'b0;

        go(2, 0);
        wait_fall(2, c);
        chk("fast_fall", c, t_start[2] + 30);
        step(20);
        rd_chk(2, "midshift0", 1'b0, 5'b01000);
        rd_chk(2, "midshift1", 1'b0, 5'b01000);
        fsx[2] = 1'b1;
        step(1);
        fsx[2] = 1'b0;
        step(5);
        chk("busy_before_rst", 32'(busy[2]), 1);
        rst = 1'b1;
        step(1);
        for (int id = 0; id < 3; id++) chk("rst_midshift", 32'(outv(id)), 32'(5'b10000));
        rst = 1'b0;
        start = '0;
        step(2);
        chk("idle_after_rst", 32'(outv(2)), 32'(5'b10000));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
